// File: rtl/operand_read_stage_pkg.sv
// rtl/operand_read_stage_pkg.sv - shared types for the operand read stage
package operand_read_stage_pkg;
  localparam int XLEN = 32;
  localparam int SB_CNT_W_DEFAULT = 2;

  typedef logic [31:0]       Addr;
  typedef logic [31:0]       Inst;
  typedef logic [7:0]        IId;
  typedef logic [4:0]        UInt5;
  typedef logic [XLEN-1:0]   UIntX;
  typedef logic [SB_CNT_W_DEFAULT-1:0] SbCnt;

  typedef struct packed {
    Addr  pc;
    Inst  inst;
    IId   inst_id;
    UInt5 rd;
    logic rf_wen;
    UIntX rs1_data;
    UIntX rs2_data;
  } OpReadOut;

  // x0 reads as zero; a commit landing this cycle wins over the not-yet-updated regfile
  function automatic UIntX bypass_read(input UInt5 rs, input logic commit, input UInt5 wb_addr,
                                       input UIntX wb_data, input UIntX rf_val);
    if (rs == '0) return '0;
    if (commit && wb_addr == rs) return wb_data;
    return rf_val;
  endfunction
endpackage

// File: rtl/operand_read_stage_reg_scoreboard.sv
// rtl/operand_read_stage_reg_scoreboard.sv - per-register in-flight write counters
module reg_scoreboard
  import operand_read_stage_pkg::*;
#(
  parameter int SB_CNT_W = SB_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  UInt5 rs1,
  input  logic use_rs1,
  input  UInt5 rs2,
  input  logic use_rs2,
  input  UInt5 rd,
  input  logic rf_wen,
  input  logic issue,
  input  logic commit,
  input  UInt5 commit_addr,
  input  logic kill,
  input  UInt5 kill_addr,
  output logic busy_rs1,
  output logic busy_rs2,
  output logic full_rd
);
  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

  logic [SB_CNT_W-1:0] cnt     [32];
  logic [SB_CNT_W-1:0] cnt_nxt [32];
  logic [SB_CNT_W:0]   sum     [32];
  logic [SB_CNT_W:0]   dec     [32];
  logic [31:0]         underflow;

  // the last pending write retiring this very cycle no longer blocks a reader
  function automatic logic is_busy(input UInt5 rs, input logic use_rs,
                                   input logic [SB_CNT_W-1:0] c, input logic hit);
    return use_rs && rs != '0 && c != '0 && !(c == SB_CNT_W'(1) && hit);
  endfunction

  assign busy_rs1 = is_busy(rs1, use_rs1, cnt[rs1], commit && commit_addr == rs1);
  assign busy_rs2 = is_busy(rs2, use_rs2, cnt[rs2], commit && commit_addr == rs2);
  assign full_rd  = rf_wen && rd != '0 && cnt[rd] == CNT_MAX
                    && !(commit && commit_addr == rd) && !(kill && kill_addr == rd);

  always_comb begin
    underflow = '0;
    for (int r = 0; r < 32; r++) begin
      sum[r] = {1'b0, cnt[r]} + (SB_CNT_W+1)'(issue && rf_wen && rd == 5'(r));
      dec[r] = (SB_CNT_W+1)'(commit && commit_addr == 5'(r))
             + (SB_CNT_W+1)'(kill && kill_addr == 5'(r));
      if (r == 0 || sum[r] < dec[r]) begin
        cnt_nxt[r]   = '0;
        underflow[r] = (r != 0);
      end else begin
        cnt_nxt[r] = SB_CNT_W'(sum[r] - dec[r]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      cnt[r] <= reset ? '0 : cnt_nxt[r];
    end
  end

  no_underflow: assert property (@(posedge clk) disable iff (reset) underflow == '0);
endmodule

// File: rtl/operand_read_stage.sv
// rtl/operand_read_stage.sv - regfile read with writeback bypass, RAW stall and output register
module operand_read_stage
  import operand_read_stage_pkg::*;
#(
  parameter int SB_CNT_W = SB_CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  Addr          in_pc,
  input  Inst          in_inst,
  input  IId           in_inst_id,
  input  UInt5         in_rs1,
  input  UInt5         in_rs2,
  input  logic         in_use_rs1,
  input  logic         in_use_rs2,
  input  logic         in_rf_wen,
  input  UInt5         in_rd,
  input  UIntX [31:0]  regfile,
  input  logic         wb_valid,
  input  logic         wb_rf_wen,
  input  UInt5         wb_reg_addr,
  input  UIntX         wb_wdata,
  input  logic         kill_valid,
  input  UInt5         kill_reg_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output Addr          out_pc,
  output Inst          out_inst,
  output IId           out_inst_id,
  output UInt5         out_rd,
  output logic         out_rf_wen,
  output UIntX         out_rs1_data,
  output UIntX         out_rs2_data,
  output logic [63:0]  stall_count
);
  logic     commit;
  logic     busy_rs1;
  logic     busy_rs2;
  logic     full_rd;
  logic     fire;
  OpReadOut out_q;
  OpReadOut out_d;

  assign commit   = wb_valid && wb_rf_wen && wb_reg_addr != '0;
  assign in_ready = (!out_valid || out_ready) && !busy_rs1 && !busy_rs2 && !full_rd;
  assign fire     = in_valid && in_ready;

  reg_scoreboard #(.SB_CNT_W(SB_CNT_W)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .rs1         (in_rs1),
    .use_rs1     (in_use_rs1),
    .rs2         (in_rs2),
    .use_rs2     (in_use_rs2),
    .rd          (in_rd),
    .rf_wen      (in_rf_wen),
    .issue       (fire),
    .commit      (commit),
    .commit_addr (wb_reg_addr),
    .kill        (kill_valid),
    .kill_addr   (kill_reg_addr),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2),
    .full_rd     (full_rd)
  );

  always_comb begin
    out_d          = '0;
    out_d.pc       = in_pc;
    out_d.inst     = in_inst;
    out_d.inst_id  = in_inst_id;
    out_d.rd       = in_rd;
    out_d.rf_wen   = in_rf_wen;
    out_d.rs1_data = bypass_read(in_rs1, commit, wb_reg_addr, wb_wdata, regfile[in_rs1]);
    out_d.rs2_data = bypass_read(in_rs2, commit, wb_reg_addr, wb_wdata, regfile[in_rs2]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_q       <= '0;
      stall_count <= '0;
    end else begin
      if (fire) begin
        out_q     <= out_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && !in_ready) stall_count <= stall_count + 64'd1;
    end
  end

  assign out_pc       = out_q.pc;
  assign out_inst     = out_q.inst;
  assign out_inst_id  = out_q.inst_id;
  assign out_rd       = out_q.rd;
  assign out_rf_wen   = out_q.rf_wen;
  assign out_rs1_data = out_q.rs1_data;
  assign out_rs2_data = out_q.rs2_data;
endmodule

// File: tb/tb_operand_read_stage.sv
// tb/tb_operand_read_stage.sv - directed and randomized checks of operand_read_stage against a reference model
module tb_operand_read_stage;
  import operand_read_stage_pkg::*;

  localparam int CNT_MAX = 3;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, in_use_rs1, in_use_rs2, in_rf_wen;
  Addr  in_pc;
  Inst  in_inst;
  IId   in_inst_id;
  UInt5 in_rs1, in_rs2, in_rd;
  UIntX [31:0] rf;
  logic wb_valid, wb_rf_wen, kill_valid, out_valid, out_ready, out_rf_wen;
  UInt5 wb_reg_addr, kill_reg_addr, out_rd;
  UIntX wb_wdata, out_rs1_data, out_rs2_data;
  Addr  out_pc;
  Inst  out_inst;
  IId   out_inst_id;
  logic [63:0] stall_count;

  operand_read_stage #(.SB_CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_inst_id(in_inst_id),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rf_wen(in_rf_wen), .in_rd(in_rd), .regfile(rf),
    .wb_valid(wb_valid), .wb_rf_wen(wb_rf_wen), .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata),
    .kill_valid(kill_valid), .kill_reg_addr(kill_reg_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_inst_id(out_inst_id), .out_rd(out_rd),
    .out_rf_wen(out_rf_wen), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cnt_m [32];
  UInt5        inflight [$];
  logic        exp_valid;
  OpReadOut    exp_out;
  logic [63:0] exp_stall;
  logic        last_fired;
  logic [63:0] stall_base;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic commit_m();
    return wb_valid && wb_rf_wen && wb_reg_addr != 0;
  endfunction

  // outstanding writes to rs that remain after this cycle's commit
  function automatic logic blocked(input UInt5 rs, input logic use_rs);
    int left;
    left = cnt_m[rs];
    if (commit_m() && wb_reg_addr == rs) left = left - 1;
    return use_rs && rs != 0 && left > 0;
  endfunction

  function automatic logic model_ready();
    logic full;
    full = in_rf_wen && in_rd != 0 && cnt_m[in_rd] == CNT_MAX
           && !(commit_m() && wb_reg_addr == in_rd) && !(kill_valid && kill_reg_addr == in_rd);
    return (!exp_valid || out_ready) && !blocked(in_rs1, in_use_rs1)
           && !blocked(in_rs2, in_use_rs2) && !full;
  endfunction

  function automatic UIntX model_read(input UInt5 rs);
    if (rs == 0) return '0;
    if (commit_m() && wb_reg_addr == rs) return wb_wdata;
    return rf[rs];
  endfunction

  function automatic void drop_inflight(input UInt5 a);
    for (int i = 0; i < inflight.size(); i++) begin
      if (inflight[i] == a) begin
        inflight.delete(i);
        break;
      end
    end
  endfunction

  task automatic step();
    logic exp_rdy;
    logic f;
    UIntX o1, o2;
    @(negedge clk);
    exp_rdy = model_ready();
    check("in_ready", in_ready, exp_rdy);
    f  = in_valid && exp_rdy && !reset;
    o1 = model_read(in_rs1);
    o2 = model_read(in_rs2);
    @(posedge clk);
    #1;
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      inflight.delete();
      exp_valid = 1'b0;
      exp_out   = '0;
      exp_stall = '0;
    end else begin
      if (in_valid && !exp_rdy) exp_stall = exp_stall + 1;
      if (f) begin
        exp_valid = 1'b1;
        exp_out   = '{pc: in_pc, inst: in_inst, inst_id: in_inst_id, rd: in_rd,
                      rf_wen: in_rf_wen, rs1_data: o1, rs2_data: o2};
        if (in_rf_wen && in_rd != 0) begin
          cnt_m[in_rd]++;
          inflight.push_back(in_rd);
        end
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
      if (commit_m()) begin
        cnt_m[wb_reg_addr]--;
        drop_inflight(wb_reg_addr);
        rf[wb_reg_addr] = wb_wdata;
      end
      if (kill_valid && kill_reg_addr != 0) begin
        cnt_m[kill_reg_addr]--;
        drop_inflight(kill_reg_addr);
      end
    end
    last_fired = f;
    check("out_valid", out_valid, exp_valid);
    check("out_pc", out_pc, exp_out.pc);
    check("out_inst", out_inst, exp_out.inst);
    check("out_inst_id", out_inst_id, exp_out.inst_id);
    check("out_rd", out_rd, exp_out.rd);
    check("out_rf_wen", out_rf_wen, exp_out.rf_wen);
    check("out_rs1_data", out_rs1_data, exp_out.rs1_data);
    check("out_rs2_data", out_rs2_data, exp_out.rs2_data);
    check("stall_count", stall_count, exp_stall);
  endtask

  task automatic set_idle();
    in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0; in_rf_wen = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    wb_valid = 0; wb_rf_wen = 0; wb_reg_addr = 0; wb_wdata = 0;
    kill_valid = 0; kill_reg_addr = 0; out_ready = 1;
  endtask

  task automatic set_inst(input UInt5 rs1, input logic u1, input UInt5 rs2, input logic u2,
                          input logic wen, input UInt5 rd);
    in_valid = 1; in_pc = $urandom; in_inst = $urandom; in_inst_id = IId'($urandom);
    in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
    in_rf_wen = wen; in_rd = rd;
  endtask

  task automatic set_wb(input UInt5 a, input UIntX d);
    wb_valid = 1; wb_rf_wen = 1; wb_reg_addr = a; wb_wdata = d;
  endtask

  initial begin
    reset = 1; in_pc = 0; in_inst = 0; in_inst_id = 0;
    set_idle();
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    exp_valid = 0; exp_out = '0; exp_stall = '0; last_fired = 0;
    check("rst_valid", out_valid, 0);
    check("rst_stall", stall_count, 0);
    check("rst_rs1", out_rs1_data, 0);

    // independent read
    rf[5] = 32'h11;
    set_inst(5, 1, 0, 1, 0, 0); step();
    check("indep_valid", out_valid, 1);
    check("indep_rs1", out_rs1_data, 32'h11);
    check("indep_rs2", out_rs2_data, 0);
    set_idle();

    // RAW stall released by a same-cycle commit with bypass
    set_inst(0, 0, 0, 0, 1, 3); step();
    set_inst(3, 1, 0, 0, 0, 0); step();
    check("raw_stall", last_fired, 0);
    step();
    check("raw_stall2", last_fired, 0);
    set_wb(3, 32'hAB); step();
    check("raw_fire", last_fired, 1);
    check("raw_bypass", out_rs1_data, 32'hAB);
    set_idle();

    // backpressure
    set_inst(1, 1, 2, 1, 0, 0); step();
    out_ready = 0;
    set_inst(4, 1, 0, 0, 0, 0);
    stall_base = stall_count;
    repeat (4) step();
    check("bp_stall", stall_count - stall_base, 4);
    out_ready = 1; step();
    check("bp_release", last_fired, 1);
    set_idle(); step();

    // saturation of x7
    repeat (3) begin
      set_inst(0, 0, 0, 0, 1, 7); step();
      check("sat_fill", last_fired, 1);
    end
    set_inst(0, 0, 0, 0, 1, 7); step();
    check("sat_stall", last_fired, 0);
    set_wb(7, $urandom); step();
    check("sat_fire", last_fired, 1);
    set_idle();
    repeat (3) begin
      set_wb(7, $urandom); step();
    end
    set_idle(); step();

    // kill clears the pending write
    rf[9] = 32'h99;
    set_inst(0, 0, 0, 0, 1, 9); step();
    set_inst(9, 1, 0, 0, 0, 0); kill_valid = 1; kill_reg_addr = 9; step();
    check("kill_same_cycle", last_fired, 0);
    kill_valid = 0; step();
    check("kill_fire", last_fired, 1);
    check("kill_data", out_rs1_data, 32'h99);
    set_idle();

    // x0 never tracked
    set_inst(0, 0, 0, 0, 1, 0); step();
    set_inst(0, 1, 0, 1, 0, 0); step();
    check("x0_fire", last_fired, 1);
    set_idle();

    // reset with a held output and a pending write
    set_inst(0, 0, 0, 0, 1, 4); step();
    set_idle(); out_ready = 0; step();
    check("pre_rst_valid", out_valid, 1);
    reset = 1; step();
    reset = 0;
    check("rst2_valid", out_valid, 0);
    check("rst2_rd", out_rd, 0);
    check("rst2_stall", stall_count, 0);
    set_idle();
    set_inst(4, 1, 4, 1, 0, 0); step();
    check("rst2_fire", last_fired, 1);
    set_idle(); step();

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      set_idle();
      if ($urandom_range(0, 9) < 8)
        set_inst(UInt5'($urandom_range(0, 7)), 1'($urandom), UInt5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), UInt5'($urandom_range(0, 7)));
      out_ready = ($urandom_range(0, 9) < 7);
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        set_wb(inflight[$urandom_range(0, inflight.size() - 1)], $urandom);
      end else if (inflight.size() > 0 && $urandom_range(0, 9) == 0) begin
        kill_valid = 1;
        kill_reg_addr = inflight[$urandom_range(0, inflight.size() - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        wb_valid = 1; wb_rf_wen = 1'($urandom); wb_wdata = $urandom;
        wb_reg_addr = wb_rf_wen ? UInt5'(0) : UInt5'($urandom_range(1, 31));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
